// File: rtl/esc_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : esc_pwm_bank
// Description : Multi-channel ESC pulse generator. A shared 1 us timebase
//               drives a frame counter. Each channel maps its throttle to a
//               pulse width in microseconds. Throttle updates are
//               double-buffered and applied at frame boundaries. An arming
//               FSM holds the motors at idle pulses for ARM_FRAMES frames
//               before throttle pulses are allowed through.
// Ports       : clock, reset      - system clock, synchronous active-high reset
//               arm               - level request to arm the motors
//               idle              - force idle pulses while armed
//               load_valid        - capture throttle into pending registers
//               throttle          - packed throttles, ch i at [i*THR_W +: THR_W]
//               pwm               - registered pulse outputs, one per channel
//               frame_start       - one-cycle pulse after each frame wrap
//               armed             - high while the FSM is in ARMED
// Revision    : 1.0 - initial release
// ============================================================================
module esc_pwm_bank #(
    parameter int NUM_CH     = 4,
    parameter int THR_W      = 8,
    parameter int CTR_LEN    = 12,
    parameter int CLK_DIV    = 50,
    parameter int PERIOD_US  = 2500,
    parameter int IDLE_US    = 900,
    parameter int MIN_US     = 1064,
    parameter int MAX_US     = 1864,
    parameter int ARM_FRAMES = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      arm,
    input  logic                      idle,
    input  logic                      load_valid,
    input  logic [NUM_CH*THR_W-1:0]   throttle,
    output logic [NUM_CH-1:0]         pwm,
    output logic                      frame_start,
    output logic                      armed
);

    localparam int SPAN   = MAX_US - MIN_US;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PROD_W = THR_W + $clog2(SPAN + 1);
    localparam int ACNT_W = $clog2(ARM_FRAMES + 1);

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMING   = 2'd1,
        S_ARMED    = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [ACNT_W-1:0]               r_arm_cnt;
    logic [ACNT_W-1:0]               w_cnt_nxt;
    logic [DIV_W-1:0]                r_div;
    logic [CTR_LEN-1:0]              r_ctr;
    logic                            w_tick;
    logic                            w_boundary;
    logic [NUM_CH-1:0][CTR_LEN-1:0]  r_pend;
    logic [NUM_CH-1:0][CTR_LEN-1:0]  r_act;
    logic [NUM_CH-1:0][CTR_LEN-1:0]  w_map;
    logic [NUM_CH-1:0][CTR_LEN-1:0]  w_act_nxt;
    logic [NUM_CH-1:0]               w_below;

    // Full-width product before the shift; result wraps to CTR_LEN bits.
    function automatic logic [CTR_LEN-1:0] map_thr(input logic [THR_W-1:0] t);
        logic [PROD_W-1:0] p;
        p = PROD_W'(t) * PROD_W'(SPAN);
        return CTR_LEN'(MIN_US) + CTR_LEN'(p >> THR_W);
    endfunction

    assign w_tick     = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_boundary = w_tick && (r_ctr == CTR_LEN'(PERIOD_US - 1));

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_map[i]   = map_thr(throttle[i*THR_W +: THR_W]);
            w_below[i] = (r_ctr < r_act[i]);
        end
    end

    // Next-state and next-active selection. Everything only moves in the
    // boundary cycle; the pulse chosen for the new frame follows the state
    // being entered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_arm_cnt;
        w_act_nxt   = '0;
        if (w_boundary) begin
            case (r_state)
                S_DISARMED: begin
                    if (arm) begin
                        w_state_nxt = S_ARMING;
                        w_cnt_nxt   = '0;
                    end
                end
                S_ARMING: begin
                    if (!arm) begin
                        w_state_nxt = S_DISARMED;
                    end else if (r_arm_cnt == ACNT_W'(ARM_FRAMES - 1)) begin
                        w_state_nxt = S_ARMED;
                    end else begin
                        w_cnt_nxt = r_arm_cnt + ACNT_W'(1);
                    end
                end
                S_ARMED: begin
                    if (!arm) begin
                        w_state_nxt = S_DISARMED;
                    end
                end
                default: w_state_nxt = S_DISARMED;
            endcase
        end
        for (int i = 0; i < NUM_CH; i++) begin
            case (w_state_nxt)
                S_ARMING: w_act_nxt[i] = CTR_LEN'(IDLE_US);
                // A load in the boundary cycle bypasses the pending stage.
                S_ARMED:  w_act_nxt[i] = idle       ? CTR_LEN'(IDLE_US) :
                                         load_valid ? w_map[i] : r_pend[i];
                default:  w_act_nxt[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div       <= '0;
            r_ctr       <= '0;
            r_state     <= S_DISARMED;
            r_arm_cnt   <= '0;
            r_pend      <= {NUM_CH{CTR_LEN'(IDLE_US)}};
            r_act       <= {NUM_CH{CTR_LEN'(IDLE_US)}};
            pwm         <= '0;
            frame_start <= 1'b0;
            armed       <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
                r_ctr <= w_boundary ? '0 : r_ctr + CTR_LEN'(1);
            end
            r_state   <= w_state_nxt;
            r_arm_cnt <= w_cnt_nxt;
            if (load_valid) begin
                r_pend <= w_map;
            end
            if (w_boundary) begin
                r_act <= w_act_nxt;
            end
            // Active holds IDLE_US out of reset, so DISARMED must gate the
            // output until the first boundary loads a real selection.
            pwm         <= w_below & {NUM_CH{r_state != S_DISARMED}};
            frame_start <= w_boundary;
            armed       <= (w_state_nxt == S_ARMED);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_esc_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_esc_pwm_bank
// Description : Self-checking bench for esc_pwm_bank using a scaled timebase
//               (2 clocks per us, 250 us frame). A frame-level reference
//               model predicts pwm/frame_start/armed every cycle; directed
//               steps pin pulse widths to hand-computed cycle counts and
//               random loads/idle toggles exercise the double buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_esc_pwm_bank;

    localparam int NUM_CH     = 4;
    localparam int THR_W      = 8;
    localparam int CTR_LEN    = 12;
    localparam int CLK_DIV    = 2;
    localparam int PERIOD_US  = 250;
    localparam int IDLE_US    = 90;
    localparam int MIN_US     = 106;
    localparam int MAX_US     = 186;
    localparam int ARM_FRAMES = 8;
    localparam int FRAME      = CLK_DIV * PERIOD_US;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     arm = 1'b0;
    logic                     idle = 1'b0;
    logic                     load_valid = 1'b0;
    logic [NUM_CH*THR_W-1:0]  throttle = '0;
    logic [NUM_CH-1:0]        pwm;
    logic                     frame_start;
    logic                     armed;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    esc_pwm_bank #(
        .NUM_CH(NUM_CH), .THR_W(THR_W), .CTR_LEN(CTR_LEN), .CLK_DIV(CLK_DIV),
        .PERIOD_US(PERIOD_US), .IDLE_US(IDLE_US), .MIN_US(MIN_US),
        .MAX_US(MAX_US), .ARM_FRAMES(ARM_FRAMES)
    ) dut (
        .clock(clock), .reset(reset), .arm(arm), .idle(idle),
        .load_valid(load_valid), .throttle(throttle), .pwm(pwm),
        .frame_start(frame_start), .armed(armed)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int map_thr(input int t);
        return (MIN_US + ((t * (MAX_US - MIN_US)) >> THR_W)) & ((1 << CTR_LEN) - 1);
    endfunction

    // ------------------------------------------------------------------
    // Reference model: cycle index since reset release gives the frame
    // position arithmetically; frame-level mode/count decide each frame's
    // effective pulse width (0 means no pulse).
    // ------------------------------------------------------------------
    int               m_n;
    int               m_mode;   // 0 disarmed, 1 arming, 2 armed
    int               m_cnt;
    int               m_pend  [NUM_CH];
    int               m_width [NUM_CH];
    logic [NUM_CH-1:0] exp_pwm;
    logic             exp_fs;
    logic             exp_armed;
    logic             m_init = 1'b0;

    always @(posedge clock) begin : model
        int j;
        int nm;
        int nc;
        int np [NUM_CH];
        int nw [NUM_CH];
        logic [NUM_CH-1:0] ep;
        logic bnd;
        m_init <= 1'b1;
        if (reset) begin
            m_n    <= 0;
            m_mode <= 0;
            m_cnt  <= 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_pend[i]  <= IDLE_US;
                m_width[i] <= 0;
            end
            exp_pwm   <= '0;
            exp_fs    <= 1'b0;
            exp_armed <= 1'b0;
        end else begin
            j   = m_n % FRAME;
            bnd = (j == FRAME - 1);
            for (int i = 0; i < NUM_CH; i++) begin
                ep[i] = ((j / CLK_DIV) < m_width[i]);
                np[i] = load_valid ? map_thr(int'(throttle[i*THR_W +: THR_W])) : m_pend[i];
                nw[i] = m_width[i];
            end
            nm = m_mode;
            nc = m_cnt;
            if (bnd) begin
                case (m_mode)
                    0: if (arm) begin nm = 1; nc = 0; end
                    1: if (!arm) nm = 0;
                       else begin
                           nc = m_cnt + 1;
                           if (nc == ARM_FRAMES) nm = 2;
                       end
                    default: if (!arm) nm = 0;
                endcase
                for (int i = 0; i < NUM_CH; i++)
                    nw[i] = (nm == 0) ? 0 : ((nm == 1 || idle) ? IDLE_US : np[i]);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                m_pend[i]  <= np[i];
                m_width[i] <= nw[i];
            end
            m_n       <= m_n + 1;
            m_mode    <= nm;
            m_cnt     <= nc;
            exp_pwm   <= ep;
            exp_fs    <= bnd;
            exp_armed <= (nm == 2);
        end
    end

    always @(negedge clock) begin : compare
        if (m_init) begin
            chk("pwm", 32'(pwm), 32'(exp_pwm));
            chk("frame_start", 32'(frame_start), 32'(exp_fs));
            chk("armed", 32'(armed), 32'(exp_armed));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at negedge)
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_fs();
        int t;
        t = 0;
        while (frame_start !== 1'b1 && t < 2 * FRAME) begin
            @(negedge clock);
            t++;
        end
        if (frame_start !== 1'b1) chk("frame_start timeout", 0, 1);
    endtask

    task automatic next_frame();
        @(negedge clock);
        wait_fs();
    endtask

    task automatic do_load(input logic [NUM_CH*THR_W-1:0] v);
        throttle   = v;
        load_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    // Measures one whole frame from its frame_start; expectations in cycles.
    task automatic check_widths(input string tag, input int e0, input int e1,
                                input int e2, input int e3);
        int cnt [NUM_CH];
        int e   [NUM_CH];
        e = '{e0, e1, e2, e3};
        wait_fs();
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
        for (int k = 0; k < FRAME; k++) begin
            for (int i = 0; i < NUM_CH; i++) if (pwm[i] === 1'b1) cnt[i]++;
            @(negedge clock);
        end
        for (int i = 0; i < NUM_CH; i++)
            chk($sformatf("%s ch%0d width", tag, i), cnt[i], e[i]);
    endtask

    initial begin : watchdog
        repeat (60000) @(posedge clock);
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : main
        int gap;
        int highs;
        logic [NUM_CH*THR_W-1:0] rv;

        // 1: reset, disarmed frames
        cyc(5);
        chk("reset pwm", 32'(pwm), 0);
        chk("reset armed", 32'(armed), 0);
        reset = 1'b0;
        wait_fs();
        for (int f = 0; f < 2; f++) begin
            gap = 0;
            do begin
                @(negedge clock);
                gap++;
            end while (frame_start !== 1'b1 && gap < 2 * FRAME);
            chk("frame gap", gap, 500);
        end
        check_widths("disarmed", 0, 0, 0, 0);

        // 2: arming sequence with full throttle pending
        do_load({NUM_CH{8'hFF}});
        arm = 1'b1;
        next_frame();
        chk("armed during arming", 32'(armed), 0);
        for (int f = 0; f < ARM_FRAMES; f++)
            check_widths($sformatf("arming f%0d", f), 180, 180, 180, 180);
        chk("armed at 9th frame_start", 32'(armed), 1);
        check_widths("first armed", 370, 370, 370, 370);

        // 3: mid-frame load takes effect next frame only
        fork
            check_widths("s3 current", 370, 370, 370, 370);
            begin
                cyc(100);
                do_load({8'd64, 8'd255, 8'd128, 8'd0});
            end
        join
        check_widths("s3 mapped", 212, 292, 370, 252);

        // 4: idle high across exactly one boundary
        idle = 1'b1;
        check_widths("s4 before idle", 212, 292, 370, 252);
        idle = 1'b0;
        check_widths("s4 idle frame", 180, 180, 180, 180);
        check_widths("s4 resumed", 212, 292, 370, 252);

        // 5: two loads in a frame plus one in the boundary cycle
        fork
            check_widths("s5 current", 212, 292, 370, 252);
            begin
                cyc(50);
                rv = $urandom;
                do_load(rv);
                cyc(100);
                rv = $urandom;
                do_load(rv);
                cyc(FRAME - 1 - 152);
                do_load({8'hC0, 8'h80, 8'h40, 8'h10});
            end
        join
        check_widths("s5 boundary load", 222, 252, 292, 332);

        // Randomized loads and idle toggles, checked by the model
        for (int k = 0; k < 5000; k++) begin
            load_valid = ($urandom_range(0, 149) == 0);
            throttle   = $urandom;
            if ($urandom_range(0, 799) == 0) idle = ~idle;
            @(negedge clock);
        end
        load_valid = 1'b0;
        idle       = 1'b0;

        // 6: reset in the middle of a full-throttle pulse
        do_load({NUM_CH{8'hFF}});
        next_frame();
        cyc(100);
        chk("pwm mid pulse", 32'(pwm), 32'hF);
        reset = 1'b1;
        @(negedge clock);
        chk("pwm after reset", 32'(pwm), 0);
        cyc(2);
        reset = 1'b0;
        arm   = 1'b0;
        highs = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (pwm !== '0) highs++;
            @(negedge clock);
        end
        chk("no remnant pulse", highs, 0);
        chk("armed after reset", 32'(armed), 0);

        // arm dropped mid-ARMING returns to DISARMED at the next boundary
        arm = 1'b1;
        next_frame();
        fork
            check_widths("s6 arming", 180, 180, 180, 180);
            begin
                cyc(200);
                arm = 1'b0;
            end
        join
        check_widths("s6 disarmed", 0, 0, 0, 0);
        chk("armed after disarm", 32'(armed), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/esc_pwm_bank.md
Name: esc_pwm_bank

Overview:
Multi-channel ESC pulse generator with a shared 1 µs timebase and frame counter. Each channel converts a THR_W-bit throttle setting arithmetically into a pulse width in microseconds. Throttle updates are double-buffered and applied only at frame boundaries. An arming state machine prevents motor drive until idle pulses have been emitted for ARM_FRAMES frames. It sits between the flight-control mixer and the ESC output pins.

Parameters:
NUM_CH, 4, number of motor channels
THR_W, 8, throttle width per channel
CTR_LEN, 12, width of µs counter and pulse registers
CLK_DIV, 50, clock cycles per 1 µs tick (50 MHz clock)
PERIOD_US, 2500, frame period in µs (400 Hz)
IDLE_US, 900, pulse width while arming, idling, or in reset-released idle
MIN_US, 1064, pulse width at throttle 0
MAX_US, 1864, nominal full-scale pulse width (SPAN = MAX_US-MIN_US)
ARM_FRAMES, 8, idle frames required before ARMED

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
arm  in  1  level request to arm the motors
idle  in  1  when high and ARMED, all channels output IDLE_US
load_valid  in  1  capture throttle into the pending registers this cycle
throttle  in  NUM_CH*THR_W  packed settings; channel i = bits [i*THR_W +: THR_W]
pwm  out  NUM_CH  pulse outputs
frame_start  out  1  single-cycle pulse at each frame wrap
armed  out  1  high while in ARMED

Behaviour:
- Reset (synchronous, active-high) values:
  - divider, µs counter: 0
  - state: DISARMED
  - pending and active pulse registers: IDLE_US
  - pwm: 0; frame_start: 0; armed: 0
- Tick generation:
  - Divider counts 0..CLK_DIV-1; tick is high during the cycle the divider equals CLK_DIV-1.
  - On tick, µs counter ctr increments; at PERIOD_US-1 it wraps to 0.
- Frame boundary:
  - The wrap cycle is the boundary cycle; frame_start is registered high for exactly one cycle following it.
  - All active registers update and state transitions occur only in the boundary cycle.
- Mapping:
  - pulse_i = MIN_US + ((throttle_i * SPAN) >> THR_W), computed at full product width, then truncated to CTR_LEN.
  - Examples: 0 -> 1064; 128 -> 1464; 255 -> 1860.
- Load handshake:
  - Load is always accepted; there is no ready signal.
  - On load_valid, all NUM_CH mapped values are written to the pending registers; the last load before a boundary wins.
  - If load_valid coincides with the boundary cycle, the new values go straight into active (bypass) and are used in the frame that starts.
- Per-channel pulse selection, evaluated at the boundary:
  - DISARMED: active = 0, so the output stays low.
  - ARMING: active = IDLE_US.
  - ARMED with idle=1: active = IDLE_US.
  - ARMED with idle=0: active = pending.
- Output:
  - pwm[i] is registered: pwm[i] <= (ctr < active_i).
  - Latency is one cycle from the counter value; the rising edge follows the boundary by one cycle.
  - Pulses are never truncated or extended mid-frame.
- State machine, with transitions at boundaries only:
  - DISARMED -> ARMING when arm=1. The frame counter clears, and the idle pulse starts in that same new frame.
  - ARMING -> ARMED after ARM_FRAMES completed ARMING frames.
  - ARMING -> DISARMED when arm=0.
  - ARMED -> DISARMED when arm=0.
  - arm changes between boundaries take effect only at the next boundary.
- armed is registered from the state; it is high for exactly the ARMED frames.
- Reset mid-frame or mid-pulse: pwm goes to 0 on the next clock. The bench must check that no remnant of the interrupted pulse appears once reset is released.
- Throttle values that would exceed 2^CTR_LEN-1 wrap; SPAN must satisfy MIN_US+SPAN < PERIOD_US. This is a parameter rule, not checked in RTL.

Test Plan:
1. Reset, arm=0, run 3 frames -> pwm=0 on all channels; frame_start pulses every 125000 cycles; armed=0.
2. arm=1, throttle=0xFF on all channels, loaded -> 8 frames of 900 µs pulses (45000 cycles high each); armed rises at the 9th frame_start; that frame carries 1860 µs pulses.
3. ARMED, load ch0=0, ch1=128, ch2=255, ch3=64 mid-frame -> the current frame is unchanged; the next frame shows 1064/1464/1860/1264 µs.
4. ARMED, idle=1 for one boundary, then 0 -> exactly that frame is 900 µs on all channels, after which throttle pulses resume.
5. Two loads in one frame, plus a load coinciding with the boundary cycle -> the boundary load's values appear in the frame just started.
6. Assert reset during a 1860 µs pulse -> pwm low next cycle; after release, DISARMED with outputs low; arm=0 mid-ARMING -> DISARMED at the next boundary.
